// File: rtl/fp_pkg.sv
// Shared floating-point constants, format derivation and FSM state encoding.
package fp_pkg;

  // Mantissa width for the supported widths (single when not 64).
  function automatic int unsigned mant_bits(input int unsigned n);
    return (n == 64) ? 52 : 23;
  endfunction

  // Exponent field width.
  function automatic int unsigned exp_bits(input int unsigned n);
    return (n == 64) ? 11 : 8;
  endfunction

  // Exponent bias.
  function automatic int unsigned exp_bias(input int unsigned n);
    return (n == 64) ? 1023 : 127;
  endfunction

  // Width-independent patterns; callers truncate to N bits.
  localparam logic [63:0] NanBits  = '1;
  localparam logic [63:0] ZeroBits = '0;

  // Positive infinity: exponent field all ones, mantissa and sign zero.
  function automatic logic [63:0] inf_bits(input int unsigned n);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i >= mant_bits(n) && i < n - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDivide = 2'd1,
    StNorm   = 2'd2,
    StDone   = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/mant_divider.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
module mant_divider #(
  parameter int unsigned M = 23
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [M-1:0] mant_a_i,
  input  logic [M-1:0] mant_b_i,
  output logic [M+1:0] quot_o,
  output logic         last_o
);

  localparam int unsigned CW = $clog2(M + 2);

  logic [M+1:0]  rem_q, rem_d;
  logic [M:0]    div_q, div_d;
  logic [M+1:0]  quot_q, quot_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [M+1:0] div_ext;
  logic [M+1:0] diff;
  logic [M+1:0] kept;
  logic         ge;

  assign div_ext = {1'b0, div_q};
  assign ge      = (rem_q >= div_ext);
  assign diff    = rem_q - div_ext;
  // Remainder stays below 2*divisor, so the shifted-out MSB is always zero.
  assign kept    = ge ? diff : rem_q;

  // Next-state for load and iteration steps.
  always_comb begin
    rem_d  = rem_q;
    div_d  = div_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      rem_d  = {2'b01, mant_a_i};
      div_d  = {1'b1, mant_b_i};
      quot_d = '0;
      cnt_d  = '0;
    end else if (step_i) begin
      rem_d  = kept << 1;
      quot_d = {quot_q[M:0], ge};
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      div_q  <= div_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o = quot_q;
  // High during the step that produces the final quotient bit.
  assign last_o = (cnt_q == CW'(M + 1));

endmodule

// File: rtl/fp_divider.sv
// IEEE-754 layout divider with truncation, saturation and special-case bypass.
module fp_divider
  import fp_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Result
);

  localparam int unsigned M  = mant_bits(N);
  localparam int unsigned E  = exp_bits(N);
  localparam int unsigned EW = E + 2;

  localparam logic [N-1:0] QNan   = N'(NanBits);
  localparam logic [N-1:0] PosInf = N'(inf_bits(N));
  localparam logic [N-1:0] PosZero = N'(ZeroBits);

  localparam logic signed [EW-1:0] BiasW   = EW'(exp_bias(N));
  localparam logic signed [EW-1:0] ExpMax  = EW'((1 << E) - 1);
  localparam logic signed [EW-1:0] ExpZero = '0;
  localparam logic signed [EW-1:0] ExpOne  = EW'(1);

  fsm_state_e state_q, state_d;
  logic [N-1:0]           result_q, result_d;
  logic                   sign_q, sign_d;
  logic signed [EW-1:0]   exp_q, exp_d;

  logic                   load, step, last;
  logic [M+1:0]           quot;

  // Operand fields.
  logic         s_a, s_b;
  logic [E-1:0] e_a, e_b;
  logic [M-1:0] m_a, m_b;
  assign s_a = A[N-1];
  assign s_b = B[N-1];
  assign e_a = A[N-2:M];
  assign e_b = B[N-2:M];
  assign m_a = A[M-1:0];
  assign m_b = B[M-1:0];

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  assign a_nan  = (&e_a) && (|m_a);
  assign b_nan  = (&e_b) && (|m_b);
  assign a_inf  = (&e_a) && !(|m_a);
  assign b_inf  = (&e_b) && !(|m_b);
  assign a_zero = !(|e_a) && !(|m_a);
  assign b_zero = !(|e_b) && !(|m_b);

  logic signed [EW-1:0] exp_calc;
  assign exp_calc = $signed({2'b00, e_a}) - $signed({2'b00, e_b}) + BiasW;

  // Special-case classification, first match wins.
  logic         special;
  logic [N-1:0] special_res;
  logic [N-1:0] signed_inf;
  always_comb begin
    signed_inf        = PosInf;
    signed_inf[N-1]   = s_a ^ s_b;
    special           = 1'b1;
    special_res       = PosZero;
    if (a_nan || b_nan)        special_res = QNan;
    else if (a_zero && b_zero) special_res = QNan;
    else if (a_inf && b_inf)   special_res = QNan;
    else if (b_zero)           special_res = signed_inf;
    else if (a_inf)            special_res = signed_inf;
    else if (b_inf)            special_res = PosZero;
    else if (a_zero)           special_res = PosZero;
    else                       special     = 1'b0;
  end

  // Normalise the quotient into (1, 2) and saturate the exponent.
  logic signed [EW-1:0] exp_n;
  logic [M-1:0]         mant_n;
  logic [N-1:0]         norm_res;
  always_comb begin
    if (quot[M+1]) begin
      exp_n  = exp_q;
      mant_n = quot[M:1];
    end else begin
      exp_n  = exp_q - ExpOne;
      mant_n = quot[M-1:0];
    end
    if (exp_n >= ExpMax) begin
      norm_res      = PosInf;
      norm_res[N-1] = sign_q;
    end else if (exp_n <= ExpZero) begin
      norm_res = PosZero;
    end else begin
      norm_res = {sign_q, exp_n[E-1:0], mant_n};
    end
  end

  // Control FSM next-state and datapath strobes.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    load     = 1'b0;
    step     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_d = s_a ^ s_b;
          exp_d  = exp_calc;
          if (special) begin
            result_d = special_res;
            state_d  = StDone;
          end else begin
            load    = 1'b1;
            state_d = StDivide;
          end
        end
      end
      StDivide: begin
        step = 1'b1;
        if (last) state_d = StNorm;
      end
      StNorm: begin
        result_d = norm_res;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
    end
  end

  mant_divider #(
    .M (M)
  ) u_mant_divider (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load),
    .step_i   (step),
    .mant_a_i (m_a),
    .mant_b_i (m_b),
    .quot_o   (quot),
    .last_o   (last)
  );

  assign busy   = (state_q == StDivide) || (state_q == StNorm);
  assign done   = (state_q == StDone);
  assign Result = result_q;

endmodule

// File: tb/tb_fp_divider.sv
// Randomised self-checking bench for fp_divider (N=32) against an arithmetic model.
module tb_fp_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] res;

  int n_checks = 0;
  int n_fail   = 0;

  fp_divider #(
    .N (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (op_a),
    .B      (op_b),
    .busy   (busy),
    .done   (done),
    .Result (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // True when either operand is zero, infinity or NaN.
  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF) ||
           (a[30:0] == 31'h0) || (b[30:0] == 31'h0);
  endfunction

  // Reference quotient: integer division of the significands, then normalise.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic            s;
    int              ea, eb, e;
    longint unsigned ma, mb, q, mant;
    bit              an, bn, ai, bi, az, bz;
    logic [31:0]     r;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = 64'(a[22:0]);
    mb = 64'(b[22:0]);
    an = (ea == 255) && (ma != 0);
    bn = (eb == 255) && (mb != 0);
    ai = (ea == 255) && (ma == 0);
    bi = (eb == 255) && (mb == 0);
    az = (ea == 0) && (ma == 0);
    bz = (eb == 0) && (mb == 0);
    if (an || bn)    return 32'hFFFF_FFFF;
    if (az && bz)    return 32'hFFFF_FFFF;
    if (ai && bi)    return 32'hFFFF_FFFF;
    if (bz || ai)    return {s, 8'hFF, 23'h0};
    if (bi || az)    return 32'h0;
    q = ((64'h80_0000 + ma) << 24) / (64'h80_0000 + mb);
    e = ea - eb + 127;
    if (q >= 64'h100_0000) begin
      mant = (q >> 1) & 64'h7F_FFFF;
    end else begin
      mant = q & 64'h7F_FFFF;
      e    = e - 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return 32'h0;
    r = {s, e[7:0], mant[22:0]};
    return r;
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [7:0] e;
    e = 8'($urandom_range(100, 150));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_operand();
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return {1'($urandom), 8'hFF, 23'h0};
      3: return {1'($urandom), 8'hFF, 23'($urandom) | 23'h1};
      4, 5, 6: return rand_normal();
      default: return $urandom;
    endcase
  endfunction

  // One full operation from an idle DUT; checks busy, latency, result, hold and pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] expv;
    logic [31:0] prev;
    int          exp_lat;
    int          cyc;
    bit          stable;
    expv    = ref_div(a, b);
    exp_lat = is_special(a, b) ? 0 : 26;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_busy"}, 64'(busy), 64'(exp_lat != 0));
    prev   = res;
    stable = 1'b1;
    cyc    = 0;
    while (!done && cyc < 100) begin
      if (res !== prev) stable = 1'b0;
      op_a = $urandom;
      op_b = $urandom;
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check_eq({tag, "_result"}, 64'(res), 64'(expv));
    check_eq({tag, "_hold"}, 64'(stable), 64'd1);
    @(posedge clk);
    #1;
    check_eq({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  logic [31:0] hq_a[4];
  logic [31:0] hq_b[4];
  int          cyc;
  int          dcount;

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    op_a  = 32'h40C0_0000;
    op_b  = 32'h4000_0000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    check_eq("reset_result", 64'(res), 64'd0);
    rst   = 1'b0;
    start = 1'b0;

    run_op(32'h40C0_0000, 32'h4000_0000, "six_by_two");
    run_op(32'h3F80_0000, 32'h4040_0000, "one_third");
    run_op(32'hC100_0000, 32'h3F00_0000, "neg_eight_half");
    run_op(32'h7F00_0000, 32'h0080_0000, "overflow");
    run_op(32'h3F80_0000, 32'h0000_0000, "div_by_zero");
    run_op(32'h0000_0000, 32'h0000_0000, "zero_by_zero");
    run_op(32'h0080_0000, 32'h7F00_0000, "underflow");
    run_op(32'h3F80_0000, 32'hFF80_0000, "finite_by_inf");

    for (int i = 0; i < 40; i++) begin
      run_op(rand_operand(), rand_operand(), "random");
    end

    // Abort a division with reset ten cycles in.
    @(negedge clk);
    op_a  = 32'h3F80_0000;
    op_b  = 32'h4040_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_result", 64'(res), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    dcount = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check_eq("abort_no_done", 64'(dcount), 64'd0);
    run_op(32'h40C0_0000, 32'h4000_0000, "after_abort");

    // Start held high: back-to-back operations, operands changing while busy.
    for (int i = 0; i < 4; i++) begin
      hq_a[i] = rand_normal();
      hq_b[i] = rand_normal();
    end
    @(negedge clk);
    op_a  = hq_a[0];
    op_b  = hq_b[0];
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
      end while (!busy && cyc < 10);
      check_eq("held_accept_gap", 64'(cyc), 64'd1);
      op_a = $urandom;
      op_b = $urandom;
      cyc  = 0;
      while (!done && cyc < 100) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check_eq("held_latency", 64'(cyc), 64'd26);
      check_eq("held_result", 64'(res), 64'(ref_div(hq_a[i], hq_b[i])));
      if (i < 3) begin
        op_a = hq_a[i + 1];
        op_b = hq_b[i + 1];
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      check_eq("held_pulse", 64'(done), 64'd0);
      check_eq("held_idle", 64'(busy), 64'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    check_eq("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
